// File: rtl/alu_issue.sv
// alu_issue: issue and write-back stage in front of the core ALU.
//
// Accepts one RV32I instruction at a time over a valid/ready handshake, decodes OP and
// (optionally) OP-IMM, reads operands from an internal 32x32 register file, presents them
// to the ALU, samples the ALU result after ALU_LAT cycles and writes it back.
//
// Parameters:
//   ALU_LAT      cycles from stable ALU inputs to a valid alu_rd (legal range 1..4)
//
// Optional feature macro:
//   ALU_ISSUE_OPIMM_EN  defined: OP-IMM (opcode 0010011) is decoded.
//                       undefined: OP-IMM is rejected as illegal; no immediate muxing.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   instr_valid/instr_ready    instruction handshake; instr sampled on acceptance only
//   instr                      32-bit instruction word
//   alu_rs1, alu_rs2           ALU operands (registered)
//   alu_funct3, alu_funct7     ALU operation select / modifier (registered)
//   alu_rd, alu_z              ALU result and zero flag
//   wb_valid, wb_addr, wb_data one-cycle write-back strobe, destination, value
//   illegal                    one-cycle pulse for a rejected instruction
//   zero_flag                  alu_z of the last retired instruction
//   dbg_addr, dbg_data         combinational register-file read port (x0 reads 0)

module alu_issue #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [31:0] alu_rs1,
    output logic [31:0] alu_rs2,
    output logic [2:0]  alu_funct3,
    output logic [6:0]  alu_funct7,
    input  logic [31:0] alu_rd,
    input  logic        alu_z,
    output logic        wb_valid,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        illegal,
    output logic        zero_flag,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
`ifdef ALU_ISSUE_OPIMM_EN
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
`endif

    typedef enum logic [1:0] {StIdle, StExec, StWb, StIll} state_e;

    state_e      state;
    logic [2:0]  cnt;       // remaining EXEC cycles, loaded with ALU_LAT
    logic [4:0]  rd_q;      // destination of the instruction in flight
    logic [31:0] regs [32];

    // Field extraction
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    assign opcode  = instr[6:0];
    assign f3      = instr[14:12];
    assign f7      = instr[31:25];
    assign rs1_idx = instr[19:15];
    assign rs2_idx = instr[24:20];
    assign rs1_val = (rs1_idx == 5'd0) ? 32'd0 : regs[rs1_idx];
    assign rs2_val = (rs2_idx == 5'd0) ? 32'd0 : regs[rs2_idx];

    // Decode: legality, second operand and funct7 to present to the ALU
    logic        dec_legal;
    logic [31:0] dec_rs2;
    logic [6:0]  dec_f7;

    always_comb begin
        dec_legal = 1'b0;
        dec_rs2   = rs2_val;
        dec_f7    = 7'h00;
        // opcode compare covers instr[1:0] == 2'b11
        if (opcode == OPC_OP) begin
            dec_f7    = f7;
            dec_legal = (f7 == 7'h00) ||
                        ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
        end
`ifdef ALU_ISSUE_OPIMM_EN
        else if (opcode == OPC_OPIMM) begin
            if (f3 == 3'b001) begin
                dec_rs2   = {27'd0, instr[24:20]};
                dec_legal = (f7 == 7'h00);
            end else if (f3 == 3'b101) begin
                dec_rs2   = {27'd0, instr[24:20]};
                dec_legal = (f7 == 7'h00) || (f7 == 7'h20);
                dec_f7    = (f7 == 7'h20) ? 7'h20 : 7'h00;
            end else begin
                // ADDI and friends: funct7 stays 0x00 whatever the immediate holds
                dec_rs2   = {{20{instr[31]}}, instr[31:20]};
                dec_legal = 1'b1;
            end
        end
`endif
    end

    // Ready is gated by rst_n so it reads 0 for the whole time reset is held.
    assign instr_ready = rst_n && (state == StIdle);

    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs[dbg_addr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= StIdle;
            cnt        <= 3'd0;
            rd_q       <= 5'd0;
            alu_rs1    <= 32'd0;
            alu_rs2    <= 32'd0;
            alu_funct3 <= 3'd0;
            alu_funct7 <= 7'd0;
            wb_valid   <= 1'b0;
            wb_addr    <= 5'd0;
            wb_data    <= 32'd0;
            illegal    <= 1'b0;
            zero_flag  <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else begin
            wb_valid <= 1'b0;
            illegal  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (instr_valid) begin
                        if (dec_legal) begin
                            rd_q       <= instr[11:7];
                            alu_rs1    <= rs1_val;
                            alu_rs2    <= dec_rs2;
                            alu_funct3 <= f3;
                            alu_funct7 <= dec_f7;
                            cnt        <= 3'(ALU_LAT);
                            state      <= StExec;
                        end else begin
                            illegal <= 1'b1;
                            state   <= StIll;
                        end
                    end
                end
                StExec: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        wb_data   <= alu_rd;
                        zero_flag <= alu_z;
                        wb_addr   <= rd_q;
                        wb_valid  <= 1'b1;
                        state     <= StWb;
                    end
                end
                StWb: begin
                    if (wb_addr != 5'd0) begin
                        regs[wb_addr] <= wb_data;
                    end
                    state <= StIdle;
                end
                StIll: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: two DUT lanes (ALU_LAT = 1 and 4), each with its own ALU stub,
// architectural register model, driver and scoreboard monitor.
module tb_alu_issue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit done [2];

`ifdef ALU_ISSUE_OPIMM_EN
    localparam bit OPIMM_EN = 1'b1;
`else
    localparam bit OPIMM_EN = 1'b0;
`endif

    typedef struct {
        bit          legal;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] res;
        int          due;
    } exp_t;

    task automatic chk(input int lane, input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL lane%0d %s: got 0x%08h, expected 0x%08h", lane, name, act, req);
        end
    endtask

    // RV32I integer operation selected by funct3 and the alternate (SUB/SRA) bit.
    function automatic logic [31:0] alu_fn(input logic [2:0] f3, input bit alt,
                                           input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return alt ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return {31'd0, $signed(a) < $signed(b)};
            3'd3:    return {31'd0, a < b};
            3'd4:    return a ^ b;
            3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm;
        int unsigned k, p;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = 3'($urandom_range(0, 7));
        imm = 12'($urandom);
        p   = $urandom_range(0, 9);
        f7  = (p < 6) ? 7'h00 : (p < 9) ? 7'h20 : 7'($urandom);
        k   = $urandom_range(0, 9);
        if (k < 4) return {f7, rs2, rs1, f3, rd, 7'h33};
        if (k < 8) begin
            if (f3 == 3'd1 || f3 == 3'd5) return {f7, rs2, rs1, f3, rd, 7'h13};
            return {imm, rs1, f3, rd, 7'h13};
        end
        if (k == 8) return {imm, rs1, 3'b010, rd, 7'h03};
        return {f7, rs2, rs1, f3, rd, 5'b01100, 2'($urandom_range(0, 2))};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int unsigned LAT  = (g == 0) ? 1 : 4;
        localparam int          LANE = g;

        logic        rst_n;
        logic        instr_valid;
        logic        instr_ready;
        logic [31:0] instr;
        logic [31:0] alu_rs1, alu_rs2;
        logic [2:0]  alu_funct3;
        logic [6:0]  alu_funct7;
        logic [31:0] alu_rd;
        logic        alu_z;
        logic        wb_valid;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        illegal;
        logic        zero_flag;
        logic [4:0]  dbg_addr;
        logic [31:0] dbg_data;

        alu_issue #(.ALU_LAT(LAT)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .instr_valid(instr_valid),
            .instr_ready(instr_ready),
            .instr      (instr),
            .alu_rs1    (alu_rs1),
            .alu_rs2    (alu_rs2),
            .alu_funct3 (alu_funct3),
            .alu_funct7 (alu_funct7),
            .alu_rd     (alu_rd),
            .alu_z      (alu_z),
            .wb_valid   (wb_valid),
            .wb_addr    (wb_addr),
            .wb_data    (wb_data),
            .illegal    (illegal),
            .zero_flag  (zero_flag),
            .dbg_addr   (dbg_addr),
            .dbg_data   (dbg_data)
        );

        // ALU stub: result is only correct once inputs have been stable for LAT cycles;
        // before that it returns the complement so early sampling is visible.
        logic [31:0] p_rs1 = '0, p_rs2 = '0;
        logic [2:0]  p_f3 = '0;
        logic [6:0]  p_f7 = '0;
        int          age = 0;
        int          eff;
        logic [31:0] good;

        always_comb begin
            good = alu_fn(alu_funct3, alu_funct7 == 7'h20, alu_rs1, alu_rs2);
            eff  = ({alu_rs1, alu_rs2, alu_funct3, alu_funct7} !=
                    {p_rs1, p_rs2, p_f3, p_f7}) ? 1 : age + 1;
            alu_rd = (eff >= int'(LAT)) ? good : ~good;
            alu_z  = (alu_rd == 32'd0);
        end

        always @(posedge clk) begin
            p_rs1 <= alu_rs1;
            p_rs2 <= alu_rs2;
            p_f3  <= alu_funct3;
            p_f7  <= alu_funct7;
            age   <= (eff > 8) ? 8 : eff;
        end

        exp_t        sb[$];
        logic [31:0] mregs [32];

        // Architectural model of one instruction against the register model.
        function automatic exp_t model(input logic [31:0] w);
            exp_t e;
            logic [2:0] f3;
            logic [6:0] f7;
            bit alt;
            f3 = w[14:12];
            f7 = w[31:25];
            alt = 1'b0;
            e.legal = 1'b0;
            e.rd  = w[11:7];
            e.a   = mregs[w[19:15]];
            e.b   = 32'd0;
            e.f3  = f3;
            e.f7  = 7'h00;
            e.due = 0;
            if (w[6:0] == 7'h33) begin
                e.legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                e.b = mregs[w[24:20]];
                e.f7 = f7;
                alt = (f7 == 7'h20);
            end else if (OPIMM_EN && w[6:0] == 7'h13) begin
                if (f3 == 3'd1) begin
                    e.legal = (f7 == 7'h00);
                    e.b = {27'd0, w[24:20]};
                end else if (f3 == 3'd5) begin
                    e.legal = (f7 == 7'h00) || (f7 == 7'h20);
                    e.b = {27'd0, w[24:20]};
                    alt = (f7 == 7'h20);
                end else begin
                    e.legal = 1'b1;
                    e.b = {{20{w[31]}}, w[31:20]};
                end
                e.f7 = alt ? 7'h20 : 7'h00;
            end
            e.res = alu_fn(f3, alt, e.a, e.b);
            return e;
        endfunction

        // Called at a negedge; returns at the negedge of the cycle after acceptance.
        task automatic send(input logic [31:0] w, input bit keep, output int acc,
                            output bit legal);
            exp_t e;
            int n;
            n = 0;
            instr = w;
            instr_valid = 1'b1;
            while (!instr_ready && n < 40) begin
                @(negedge clk);
                n++;
            end
            acc = cyc;
            legal = 1'b0;
            if (!instr_ready) begin
                chk(LANE, "ready_timeout", 32'(instr_ready), 32'd1);
                instr_valid = 1'b0;
                return;
            end
            e = model(w);
            e.due = e.legal ? cyc + int'(LAT) + 1 : cyc + 1;
            legal = e.legal;
            sb.push_back(e);
            if (e.legal && e.rd != 5'd0) mregs[e.rd] = e.res;
            @(negedge clk);
            if (!keep) instr_valid = 1'b0;
            if (e.legal) begin
                chk(LANE, "t1_alu_rs1", alu_rs1, e.a);
                chk(LANE, "t1_alu_rs2", alu_rs2, e.b);
                chk(LANE, "t1_funct3_funct7", 32'({alu_funct3, alu_funct7}),
                    32'({e.f3, e.f7}));
            end
        endtask

        task automatic drain();
            int n;
            n = 0;
            while (sb.size() != 0 && n < 60) begin
                @(negedge clk);
                n++;
            end
            chk(LANE, "drain_pending", sb.size(), 32'd0);
            repeat (2) @(negedge clk);
        endtask

        task automatic sweep(input string tag);
            for (int r = 0; r < 32; r++) begin
                dbg_addr = 5'(r);
                #1;
                chk(LANE, $sformatf("%s_dbg_x%0d", tag, r), dbg_data, mregs[r]);
            end
            @(negedge clk);
        endtask

        task automatic chk_zero(input string tag);
            chk(LANE, {tag, "_alu_rs1"}, alu_rs1, 32'd0);
            chk(LANE, {tag, "_alu_rs2"}, alu_rs2, 32'd0);
            chk(LANE, {tag, "_wb_data"}, wb_data, 32'd0);
            chk(LANE, {tag, "_ctrl_outs"}, 32'({instr_ready, alu_funct3, alu_funct7, wb_valid,
                                               wb_addr, illegal, zero_flag}), 32'd0);
        endtask

        // Driver
        initial begin
            int acc, pacc, n;
            bit lg, plg;
            for (int r = 0; r < 32; r++) mregs[r] = 32'd0;
            rst_n = 1'b0;
            instr_valid = 1'b0;
            instr = 32'd0;
            dbg_addr = 5'd0;
            repeat (3) @(negedge clk);
            chk_zero("reset");
            rst_n = 1'b1;
            @(negedge clk);
            chk(LANE, "ready_after_reset", 32'(instr_ready), 32'd1);

            send(32'h01400093, 1'b0, acc, lg);   // ADDI x1,x0,20
            send(32'h01E00113, 1'b0, acc, lg);   // ADDI x2,x0,30
            send(32'h402081B3, 1'b0, acc, lg);   // SUB  x3,x1,x2
            send(32'h4031D213, 1'b0, acc, lg);   // SRAI x4,x3,3
            send(32'h4020F1B3, 1'b0, acc, lg);   // funct7 0x20 on AND
            send(32'h00002083, 1'b0, acc, lg);   // LOAD
            send(32'h00500013, 1'b0, acc, lg);   // ADDI x0,x0,5
            drain();
            sweep("dir");

            // instr_valid held high: accept spacing is LAT+2 (legal) or 2 (illegal)
            pacc = 0;
            plg = 1'b0;
            for (int i = 0; i < 24; i++) begin
                send(rand_instr(), 1'b1, acc, lg);
                if (i > 0) chk(LANE, "accept_spacing", 32'(acc - pacc),
                               plg ? LAT + 2 : 32'd2);
                pacc = acc;
                plg = lg;
            end
            instr_valid = 1'b0;
            drain();
            sweep("cont");

            for (int i = 0; i < 60; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send(rand_instr(), 1'b0, acc, lg);
            end
            drain();
            sweep("rand");

            // Reset while an ADD x5,x1,x2 is in EXEC: abandoned, no write-back.
            instr = 32'h002082B3;
            instr_valid = 1'b1;
            n = 0;
            while (!instr_ready && n < 40) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
            instr_valid = 1'b0;
            rst_n = 1'b0;
            @(negedge clk);
            chk_zero("mid_reset");
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk(LANE, "ready_after_mid_reset", 32'(instr_ready), 32'd1);
            for (int r = 0; r < 32; r++) mregs[r] = 32'd0;
            sweep("post_reset");

            send(32'h01400093, 1'b0, acc, lg);
            for (int i = 0; i < 20; i++) send(rand_instr(), 1'b0, acc, lg);
            drain();
            sweep("final");
            done[g] = 1'b1;
        end

        // Monitor: pops the scoreboard whenever the DUT retires or rejects an instruction.
        initial begin
            exp_t e;
            logic [31:0] la, lb;
            logic [9:0]  lf;
            logic        lz;
            la = '0; lb = '0; lf = '0; lz = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    la = '0; lb = '0; lf = '0; lz = 1'b0;
                    continue;
                end
                if (wb_valid || illegal) begin
                    if (sb.size() == 0) begin
                        chk(LANE, "unexpected_output", 32'({wb_valid, illegal}), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk(LANE, "output_cycle", 32'(cyc), 32'(e.due));
                        chk(LANE, "wb_valid_illegal", 32'({wb_valid, illegal}),
                            e.legal ? 32'd2 : 32'd1);
                        if (e.legal) begin
                            chk(LANE, "wb_addr", 32'(wb_addr), 32'(e.rd));
                            chk(LANE, "wb_data", wb_data, e.res);
                            chk(LANE, "zero_flag", 32'(zero_flag), 32'(e.res == 32'd0));
                            chk(LANE, "wb_alu_rs1", alu_rs1, e.a);
                            chk(LANE, "wb_alu_rs2", alu_rs2, e.b);
                            chk(LANE, "wb_funct3_funct7", 32'({alu_funct3, alu_funct7}),
                                32'({e.f3, e.f7}));
                            la = e.a;
                            lb = e.b;
                            lf = {e.f3, e.f7};
                            lz = (e.res == 32'd0);
                        end else begin
                            chk(LANE, "ill_hold_rs1", alu_rs1, la);
                            chk(LANE, "ill_hold_rs2", alu_rs2, lb);
                            chk(LANE, "ill_hold_funct", 32'({alu_funct3, alu_funct7}),
                                32'(lf));
                            chk(LANE, "ill_hold_zero_flag", 32'(zero_flag), 32'(lz));
                        end
                    end
                end
            end
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(done[0] && done[1]) && t < 60000) begin
            @(posedge clk);
            t++;
        end
        if (!(done[0] && done[1])) begin
            chk(-1, "global_timeout", 32'({done[1], done[0]}), 32'd3);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
